// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Detects load-use hazards, freezes the pipe while data memory is busy,
// applies branch flushes (deferring one that arrives during a freeze) and
// flags a sticky memory-wait timeout.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_rs, id_rt              source register fields of the ID instruction
//   id_uses_rs, id_uses_rt    ID instruction actually reads rs / rt
//   ex_ReadMem, ex_rt         EX instruction is a load, and its destination
//   branch_taken              one-cycle redirect pulse from the branch unit
//   mem_busy                  data memory not ready this cycle
//   pc_stall .. memwb_bubble  per-stage hold / clear controls (combinational)
//   timeout                   sticky memory-wait timeout (registered)
//   stall_cnt                 stall cycle count
//
// Build option: define PIPE_STALL_CNT_EN to implement the 32-bit stall_cnt
// counter; otherwise stall_cnt is tied to zero.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_ReadMem,
  input  logic [4:0]  ex_rt,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        memwb_bubble,
  output logic        timeout,
  output logic [31:0] stall_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t              state;
  logic                pending_flush;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                load_use;
  logic                eff_flush;
  logic                wait_at_max;

  // Load in EX feeding a register the ID instruction reads; r0 never hazards.
  assign load_use = ex_ReadMem && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  // A deferred flush can only exist while leaving a freeze.
  assign eff_flush   = branch_taken | (pending_flush && (state == MEM_WAIT));
  assign wait_at_max = (wait_cnt == WAIT_W'(MAX_WAIT));

  // Priority decode: memory freeze, then flush, then load-use bubble.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (eff_flush) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  // Freeze state, deferred flush, wait counter and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      wait_cnt      <= '0;
      timeout       <= 1'b0;
    end else if (mem_busy) begin
      state <= MEM_WAIT;
      if (branch_taken) pending_flush <= 1'b1;
      if (!wait_at_max) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_at_max)  timeout  <= 1'b1;
    end else begin
      state         <= RUN;
      pending_flush <= 1'b0;
      wait_cnt      <= '0;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Counts every cycle the PC is held; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           stall_cnt <= 32'h0;
    else if (pc_stall) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MAX_WAIT=4).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_ReadMem, branch_taken, mem_busy;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, memwb_bubble, timeout;
  logic [31:0] stall_cnt;
  logic [6:0]  ctl;

  int checks = 0;
  int errors = 0;

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble}
  localparam logic [6:0] NONE = 7'b000_0000;
  localparam logic [6:0] LU   = 7'b110_0100;
  localparam logic [6:0] FRZ  = 7'b110_1011;
  localparam logic [6:0] FL   = 7'b001_0100;

  pipe_hazard_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_ReadMem(ex_ReadMem), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_busy(mem_busy),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_bubble(memwb_bubble), .timeout(timeout), .stall_cnt(stall_cnt)
  );

  assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                exmem_stall, memwb_bubble};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_ReadMem = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mem_busy = 1'b1;
    #3;
    chk("rst_ctl", 32'(ctl), 32'(NONE));
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    tick();
    idle();
    rst = 1'b0;
    tick();

    // Load-use on rs, then hazard gone
    ex_ReadMem = 1'b1; ex_rt = 5'd5; id_uses_rs = 1'b1; id_rs = 5'd5;
    settle(); chk("lu_rs", 32'(ctl), 32'(LU));
    tick();
    ex_ReadMem = 1'b0;
    settle(); chk("lu_rs_next", 32'(ctl), 32'(NONE));
    tick();

    // Load-use on rt; same match with rt unused gives nothing
    idle();
    ex_ReadMem = 1'b1; ex_rt = 5'd7; id_uses_rt = 1'b1; id_rt = 5'd7;
    settle(); chk("lu_rt", 32'(ctl), 32'(LU));
    tick();
    id_uses_rt = 1'b0;
    settle(); chk("lu_rt_unused", 32'(ctl), 32'(NONE));
    tick();

    // Zero register never stalls
    idle();
    ex_ReadMem = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    settle(); chk("zero_reg", 32'(ctl), 32'(NONE));
    tick();

    // Freeze with branch in cycle 2; flush deferred to the exit cycle
    idle();
    mem_busy = 1'b1;
    settle(); chk("frz_c1", 32'(ctl), 32'(FRZ));
    tick();
    branch_taken = 1'b1;
    settle(); chk("frz_c2", 32'(ctl), 32'(FRZ));
    tick();
    branch_taken = 1'b0;
    settle(); chk("frz_c3", 32'(ctl), 32'(FRZ));
    tick();
    chk("to_3burst", 32'(timeout), 32'd0);
    mem_busy = 1'b0;
    settle(); chk("frz_c4_flush", 32'(ctl), 32'(FL));
    tick();
    settle(); chk("frz_c5", 32'(ctl), 32'(NONE));
    tick();

    // Branch and load-use together: flush wins
    ex_ReadMem = 1'b1; ex_rt = 5'd9; id_uses_rs = 1'b1; id_rs = 5'd9;
    branch_taken = 1'b1;
    settle(); chk("br_and_lu", 32'(ctl), 32'(FL));
    tick();

    // Load-use during busy: freeze dominates
    branch_taken = 1'b0; mem_busy = 1'b1;
    settle(); chk("lu_in_busy", 32'(ctl), 32'(FRZ));
    tick();
    idle();
    settle(); chk("busy_exit", 32'(ctl), 32'(NONE));
    tick();

    // 5-cycle burst reaches timeout; sticky afterwards
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("to_4burst", 32'(timeout), 32'd0);
    tick();
    chk("to_5burst", 32'(timeout), 32'd1);
    mem_busy = 1'b0;
    tick();
    chk("to_sticky", 32'(timeout), 32'd1);
    settle(); chk("to_ctl", 32'(ctl), 32'(NONE));

    // Asynchronous reset mid-burst
    tick();
    mem_busy = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ctl", 32'(ctl), 32'(NONE));
    chk("arst_timeout", 32'(timeout), 32'd0);
    tick();
    idle();
    rst = 1'b0;
    settle(); chk("arst_after", 32'(ctl), 32'(NONE));
    tick();

    // Stall counter: one load-use stall plus three busy cycles
    ex_ReadMem = 1'b1; ex_rt = 5'd3; id_uses_rs = 1'b1; id_rs = 5'd3;
    tick();
    idle();
    mem_busy = 1'b1;
    tick(); tick(); tick();
    mem_busy = 1'b0;
    tick();
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd4);
`else
    chk("stall_cnt", stall_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline; drives the enable and clear controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards between the ID-stage source registers and a load in EX.
- Freezes the pipe while data memory is busy; applies branch flushes, holding a flush pending if it arrives during a freeze.
- Monitors memory-wait length and flags a sticky timeout.

Parameters:
- MAX_WAIT, 255, consecutive mem_busy cycles after which timeout sets.
- WAIT_W, 8, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_ReadMem  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the instruction in EX.
- branch_taken  in  1  one-cycle pulse from the branch unit: redirect taken.
- mem_busy  in  1  data memory not ready this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID to nop.
- idex_stall  out  1  hold ID/EX.
- idex_flush  out  1  clear ID/EX to bubble.
- exmem_stall  out  1  hold EX/MEM.
- memwb_bubble  out  1  write a bubble into MEM/WB (no WriteReg).
- timeout  out  1  sticky memory-wait timeout.
- stall_cnt  out  32  stall cycle count (see Optional Feature).

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- State: FSM {RUN, MEM_WAIT}, pending_flush bit, wait_cnt[WAIT_W-1:0], timeout bit. All control outputs are combinational from state and inputs, with no added latency.
- Reset value: rst=1 forces state=RUN and pending_flush=0, wait_cnt=0, timeout=0, stall_cnt=0. While rst=1 all stall/flush outputs are 0.
- load_use = ex_ReadMem && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
- eff_flush = branch_taken | pending_flush.
- Priority 1, mem_busy=1:
  - pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_bubble all =1; both flush outputs =0.
  - Next state MEM_WAIT.
  - If branch_taken=1, pending_flush<=1.
- Priority 2, mem_busy=0 and eff_flush=1:
  - ifid_flush=1 and idex_flush=1; no stalls.
  - pending_flush<=0; next state RUN.
  - load_use is ignored because the flushed instruction is squashed.
- Priority 3, mem_busy=0 and load_use=1:
  - pc_stall=1, ifid_stall=1, idex_flush=1 (one bubble). Other outputs 0.
  - The hazard naturally lasts one cycle, since a bubble then occupies EX.
- Otherwise all control outputs are 0 and state is RUN.
- MEM_WAIT→RUN occurs on the first cycle mem_busy=0. That cycle is evaluated with priorities 2/3, so a pending flush is applied in exactly that cycle.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on each cycle mem_busy=1.
  - Clears on any cycle mem_busy=0.
  - When wait_cnt==MAX_WAIT while mem_busy=1, timeout<=1. timeout stays 1 until rst; pipeline behaviour is unchanged by timeout.
- If branch_taken and load_use occur in the same cycle with mem_busy=0, the flush wins and no stall is issued.
- ex_rt=0 never causes a stall.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined: stall_cnt is a 32-bit counter.
  - +1 on every cycle pc_stall=1 (mem or load-use stall).
  - Wraps from 0xFFFFFFFF to 0; cleared by rst.
- Undefined: no counter register; stall_cnt is tied to 32'h0.

Test Plan:
- Load-use on rs:
  - Stimulus: ex_ReadMem=1, ex_rt=5, id_uses_rs=1, id_rs=5.
  - Response: that cycle pc_stall=ifid_stall=idex_flush=1, others 0. Next cycle with ex_ReadMem=0, all outputs 0.
- Zero register: ex_ReadMem=1, ex_rt=0, id_rs=0, id_uses_rs=1 → all outputs 0.
- Memory freeze with branch during the freeze:
  - Stimulus: mem_busy=1 for 3 cycles; branch_taken pulses in cycle 2.
  - Response: cycles 1-3 all five stall/bubble outputs =1, flushes 0. Cycle 4 (mem_busy=0): ifid_flush=idex_flush=1. Cycle 5: all 0.
- Simultaneous events: branch_taken=1 and load_use=1 with mem_busy=0 → ifid_flush=idex_flush=1, pc_stall=0.
- Timeout with MAX_WAIT=4:
  - 3-cycle busy burst → timeout stays 0.
  - 5-cycle busy burst → timeout=1 and remains 1 after mem_busy falls.
  - rst pulse mid-burst → timeout=0, state RUN, outputs 0 asynchronously.
- PIPE_STALL_CNT_EN:
  - Defined: 1 load-use stall plus 3 busy cycles → stall_cnt=4.
  - Undefined: stall_cnt=0.
